fifo_skew_ctrl: RTL and testbench
=================================

# fifo_skew_ctrl

Sequencer for a bank of `DIM` delay-buffer FIFOs, each `DIM` deep and `BITS` wide. It feeds a `DIM x DIM` operand tile into the bank one column per accepted beat, then drains the bank with a diagonal skew. In the drain, lane `i` starts shifting `i` cycles after lane 0, which is the staggered operand stream a systolic array expects. The block drives the `en` and `d` inputs of every FIFO lane and tells the downstream array which lane outputs are valid on each cycle.

## Interface
- `DIM`, default 8: number of FIFO lanes, equal to the FIFO depth. Must be ≥ 2.
- `BITS`, default 64: element width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  begin loading a tile; honoured only in IDLE.
- `wr_valid`  in  1  `wr_data` holds a valid column.
- `wr_data`  in  `[DIM-1:0][BITS-1:0]`  one column; element `i` goes to lane `i`.
- `wr_ready`  out  1  controller accepts a column this cycle.
- `drain_start`  in  1  begin skewed drain; honoured only in FULL.
- `drain_stall`  in  1  freeze the drain for this cycle.
- `fifo_en`  out  `DIM`  per-lane shift enable, to FIFO `en`.
- `fifo_d`  out  `[DIM-1:0][BITS-1:0]`  per-lane shift-in data, to FIFO `d`.
- `out_valid`  out  `DIM`  lane `i`'s FIFO `q` is a valid element this cycle and is consumed at the next edge.
- `busy`  out  1  state is LOAD or DRAIN.
- `full`  out  1  state is FULL.
- `drain_done`  out  1  one-cycle pulse when a drain completes.

## Operation
States are IDLE, LOAD, FULL and DRAIN. A beat counter `bcnt` spans 0..DIM. A skew counter `scnt` spans 0..2·DIM−2 and is `$clog2(2*DIM)` bits wide.

- **IDLE**
  - If `load_start` is high: go to LOAD and set `bcnt`=0.
  - `drain_start` is ignored.
- **LOAD**
  - `wr_ready`=1.
  - On each cycle with `wr_valid`=1 (accept):
    - `fifo_en` = all ones.
    - `fifo_d` = `wr_data`.
    - `bcnt` increments.
  - On cycles with `wr_valid`=0: `fifo_en`=0 and `fifo_d`=0.
  - On the DIM-th accept, go to FULL.
  - `load_start` and `drain_start` are ignored.
- **FULL**
  - The bank holds the tile: column 0 is at every lane's `q`, column DIM−1 is youngest.
  - `fifo_en`=0.
  - If `drain_start` is high: go to DRAIN and set `scnt`=0.
  - `load_start` is ignored.
- **DRAIN**
  - Lane `i` is active when `i ≤ scnt < i+DIM` and `drain_stall`=0.
  - For each lane: `fifo_en[i]` = `out_valid[i]` = lane active.
  - `fifo_d` = 0, so zeros are shifted in.
  - If `drain_stall`=0, `scnt` increments.
  - On the non-stalled cycle with `scnt`=2·DIM−2: go to IDLE.
  - `drain_done` is registered and pulses high in the first IDLE cycle.
  - Stall: `scnt` holds, and `fifo_en` and `out_valid` are all 0.
- `out_valid` is 0 in all states other than DRAIN.
- `fifo_en`, `fifo_d` and `out_valid` are combinational from state, the counters and the inputs. `drain_done` is a flop.
- Reset, whether in idle or mid-operation, gives:
  - state IDLE, `bcnt`=`scnt`=0;
  - all outputs 0, including `wr_ready`, `busy`, `full` and `drain_done`.
  - FIFO contents are not cleared by this block. A partially loaded bank is treated as garbage, and the next load overwrites it fully (DIM shifts).

## Timing
- Load takes exactly DIM accepted beats. `full` rises on the cycle after the DIM-th accept.
- The minimum load is DIM cycles when `wr_valid` is held high.
- Drain takes 2·DIM−1 unstalled cycles. Each lane gets exactly DIM active cycles.
- On drain cycle `c`, lane `i` presents tile element (row `i`, column `c−i`).
- `drain_done` arrives 2·DIM−1 unstalled cycles plus the number of stall cycles after the `drain_start` cycle.
- Simultaneous events:
  - `rst` has priority over everything.
  - `load_start` together with `drain_start` in IDLE: load wins.
  - `drain_stall` outside DRAIN has no effect.
  - `drain_start` held across DRAIN→IDLE does not start a new drain.
- Back-to-back operation: `load_start` in the `drain_done` cycle is accepted, and LOAD begins on the next cycle.

## Test plan
Use DIM=4 and BITS=8, with four real delay-buffer FIFO instances attached.

1. **Reset:** assert `rst` for 2 cycles → every output is 0 and state is IDLE. `drain_start` pulses in IDLE → `fifo_en` stays 0.
2. **Back-to-back load:** `load_start`, then columns 0x10-series, 0x20-series, 0x30-series, 0x40-series on consecutive cycles with `wr_valid`=1 → `fifo_en`=4'b1111 on 4 cycles, `fifo_d` equals `wr_data`, `full`=1 on the 5th cycle, `wr_ready` falls with it.
3. **Gapped load:** `wr_valid` pattern 1,0,0,1,1,0,1 → `fifo_en` is asserted only on the 4 valid cycles, and `full` asserts the cycle after the 7th.
4. **Drain:** `drain_start` from FULL → `fifo_en` sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000. `q` on each lane yields its elements in load order, lane 3 starts 3 cycles after lane 0. `drain_done` pulses once on cycle 8.
5. **Stall:** `drain_stall`=1 on drain cycles 2–3 → `fifo_en`=0 during the stall, the pattern resumes at 0111, and `drain_done` is delayed by 2 cycles.
6. **Reset mid-operation:** `rst` after 2 load beats → IDLE with all outputs 0. A fresh 4-beat load then gives a correct drain.

Source files
------------

// File: rtl/fifo_skew_ctrl_if.sv
// Handshake and FIFO-bank bus between the tile sequencer and its
// surroundings. The slave side is the controller. The master side is whoever
// feeds tiles and watches the lane outputs.
interface fifo_skew_ctrl_if #(
  parameter int DIM  = 8,
  parameter int BITS = 64
) ();

  logic                      load_start;
  logic                      wr_valid;
  logic [DIM-1:0][BITS-1:0]  wr_data;
  logic                      wr_ready;
  logic                      drain_start;
  logic                      drain_stall;
  logic [DIM-1:0]            fifo_en;
  logic [DIM-1:0][BITS-1:0]  fifo_d;
  logic [DIM-1:0]            out_valid;
  logic                      busy;
  logic                      full;
  logic                      drain_done;

  modport master (
    output load_start, wr_valid, wr_data, drain_start, drain_stall,
    input  wr_ready, fifo_en, fifo_d, out_valid, busy, full, drain_done
  );

  modport slave (
    input  load_start, wr_valid, wr_data, drain_start, drain_stall,
    output wr_ready, fifo_en, fifo_d, out_valid, busy, full, drain_done
  );

endinterface

// File: rtl/fifo_skew_ctrl.sv
// Sequencer for a bank of DIM delay-buffer FIFOs. It loads one tile column
// per accepted beat, then drains the bank with a diagonal skew so that
// lane i starts shifting i cycles after lane 0.
module fifo_skew_ctrl #(
  parameter int DIM  = 8,
  parameter int BITS = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_skew_ctrl_if.slave bus
);

  localparam int BW = $clog2(DIM + 1);
  localparam int SW = $clog2(2 * DIM);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DIM - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(2 * DIM - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [BW-1:0]            bcnt_q, bcnt_d;
  logic [SW-1:0]            scnt_q, scnt_d;
  logic                     drainDone_q, drainDone_d;

  logic [DIM-1:0]           fifoEn;
  logic [DIM-1:0][BITS-1:0] fifoD;
  logic [DIM-1:0]           outValid;
  logic [DIM-1:0]           laneActive;
  logic                     wrReady;
  logic [31:0]              scntExt;

  assign scntExt = 32'(scnt_q);

  // State and counter registers; drain_done is a registered one-cycle pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      scnt_q      <= '0;
      drainDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      scnt_q      <= scnt_d;
      drainDone_q <= drainDone_d;
    end
  end

  // Next-state logic plus the combinational lane enables, data and valids
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    scnt_d      = scnt_q;
    drainDone_d = 1'b0;
    fifoEn      = '0;
    fifoD       = '0;
    outValid    = '0;
    laneActive  = '0;
    wrReady     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          bcnt_d  = '0;
        end
      end

      LOAD: begin
        wrReady = 1'b1;
        if (bus.wr_valid) begin
          fifoEn = '1;
          fifoD  = bus.wr_data;
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BCNT_LAST) begin
            state_d = FULL;
          end
        end
      end

      FULL: begin
        if (bus.drain_start) begin
          state_d = DRAIN;
          scnt_d  = '0;
        end
      end

      DRAIN: begin
        if (!bus.drain_stall) begin
          for (int i = 0; i < DIM; i++) begin
            laneActive[i] = (scntExt >= 32'(i)) && (scntExt < 32'(i + DIM));
          end
          scnt_d = scnt_q + SW'(1);
          if (scnt_q == SCNT_LAST) begin
            state_d     = IDLE;
            scnt_d      = '0;
            drainDone_d = 1'b1;
          end
        end
        fifoEn   = laneActive;
        outValid = laneActive;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fifo_en    = fifoEn;
  assign bus.fifo_d     = fifoD;
  assign bus.out_valid  = outValid;
  assign bus.wr_ready   = wrReady;
  assign bus.busy       = (state_q == LOAD) || (state_q == DRAIN);
  assign bus.full       = (state_q == FULL);
  assign bus.drain_done = drainDone_q;

endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// Bench for fifo_skew_ctrl with DIM=4 and BITS=8. It includes a behavioural
// four-lane delay-buffer bank. A per-cycle vector table checks the control
// outputs, and a column scoreboard checks the lane data during drain.
module tb_fifo_skew_ctrl;

  localparam int DIM  = 4;
  localparam int BITS = 8;

  typedef struct {
    logic        rst;
    logic        loadStart;
    logic        wrValid;
    logic [31:0] wrData;
    logic        drainStart;
    logic        drainStall;
    logic        expWrReady;
    logic [3:0]  expEn;
    logic [31:0] expD;
    logic [3:0]  expOv;
    logic        expBusy;
    logic        expFull;
    logic        expDone;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  vec_t        vecs[$];
  logic [31:0] colQ[$];
  int          laneCnt[DIM];
  logic [7:0]  bank[DIM][DIM];

  fifo_skew_ctrl_if #(.DIM(DIM), .BITS(BITS)) bus ();

  fifo_skew_ctrl #(.DIM(DIM), .BITS(BITS)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Behavioural delay-buffer FIFOs: q of lane i is bank[i][DIM-1]
  always @(posedge clk) begin
    for (int i = 0; i < DIM; i++) begin
      if (bus.fifo_en[i]) begin
        for (int k = DIM - 1; k > 0; k--) bank[i][k] <= bank[i][k-1];
        bank[i][0] <= bus.fifo_d[i];
      end
    end
  end

  function automatic vec_t mk(input logic r, ls, wv, input logic [31:0] wd,
                              input logic ds, st, wr, input logic [3:0] en,
                              input logic [31:0] d, input logic [3:0] ov,
                              input logic b, f, dn);
    vec_t v;
    v.rst = r;  v.loadStart = ls; v.wrValid = wv; v.wrData = wd;
    v.drainStart = ds; v.drainStall = st;
    v.expWrReady = wr; v.expEn = en; v.expD = d; v.expOv = ov;
    v.expBusy = b; v.expFull = f; v.expDone = dn;
    return v;
  endfunction

  task automatic cmp(input int row, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    bus.load_start  = v.loadStart;
    bus.wr_valid    = v.wrValid;
    bus.wr_data     = v.wrData;
    bus.drain_start = v.drainStart;
    bus.drain_stall = v.drainStall;
    if (v.rst) begin
      colQ.delete();
      for (int i = 0; i < DIM; i++) laneCnt[i] = 0;
    end else if (v.wrValid && v.expWrReady) begin
      colQ.push_back(v.wrData);
    end
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    logic [31:0] col;
    logic [7:0]  expQ;
    cmp(row, "wr_ready",   32'(bus.wr_ready),   32'(v.expWrReady));
    cmp(row, "fifo_en",    32'(bus.fifo_en),    32'(v.expEn));
    cmp(row, "fifo_d",     32'(bus.fifo_d),     v.expD);
    cmp(row, "out_valid",  32'(bus.out_valid),  32'(v.expOv));
    cmp(row, "busy",       32'(bus.busy),       32'(v.expBusy));
    cmp(row, "full",       32'(bus.full),       32'(v.expFull));
    cmp(row, "drain_done", 32'(bus.drain_done), 32'(v.expDone));
    for (int i = 0; i < DIM; i++) begin
      if (bus.out_valid[i]) begin
        if (laneCnt[i] >= colQ.size()) begin
          tests++;
          fails++;
          $display("[TB] FAIL row %0d lane%0d_extra: got valid beat %0d expected only %0d",
                   row, i, laneCnt[i], colQ.size());
        end else begin
          col  = colQ[laneCnt[i]];
          expQ = col[i*8 +: 8];
          cmp(row, $sformatf("lane%0d_q", i), 32'(bank[i][DIM-1]), 32'(expQ));
          laneCnt[i]++;
        end
      end
    end
    if (v.expDone) begin
      for (int i = 0; i < DIM; i++) begin
        cmp(row, $sformatf("lane%0d_beats", i), 32'(laneCnt[i]), 32'(DIM));
        laneCnt[i] = 0;
      end
      colQ.delete();
    end
  endtask

  // Stimulus table followed by the apply/check loop
  initial begin
    localparam logic [31:0] X = 32'hDEADBEEF;
    bus.load_start  = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    bus.drain_start = 1'b0;
    bus.drain_stall = 1'b0;
    for (int i = 0; i < DIM; i++) laneCnt[i] = 0;

    // Reset, then drain_start while idle, then load_start beating drain_start
    vecs.push_back(mk(1,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,0,0,X,1,1, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,1,0,X,1,0, 0,4'h0,0,4'h0,0,0,0));
    // Back-to-back load
    vecs.push_back(mk(0,0,1,32'h13121110,0,0, 1,4'hF,32'h13121110,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h23222120,0,0, 1,4'hF,32'h23222120,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h33323130,0,0, 1,4'hF,32'h33323130,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h43424140,0,0, 1,4'hF,32'h43424140,4'h0,1,0,0));
    vecs.push_back(mk(0,1,0,X,0,0, 0,4'h0,0,4'h0,0,1,0));
    // Unstalled drain, with drain_start held across the return to idle
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h0,0,4'h0,0,1,0));
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h1,0,4'h1,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h3,0,4'h3,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h7,0,4'h7,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hF,0,4'hF,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hE,0,4'hE,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hC,0,4'hC,1,0,0));
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h8,0,4'h8,1,0,0));
    vecs.push_back(mk(0,1,0,X,1,0, 0,4'h0,0,4'h0,0,0,1));
    // Gapped load starting straight from the drain_done cycle
    vecs.push_back(mk(0,0,1,32'h53525150,0,0, 1,4'hF,32'h53525150,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 1,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 1,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h63626160,0,0, 1,4'hF,32'h63626160,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h73727170,0,0, 1,4'hF,32'h73727170,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,1, 1,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h83828180,0,0, 1,4'hF,32'h83828180,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,1, 0,4'h0,0,4'h0,0,1,0));
    // Drain with a two-cycle stall on drain cycles 2-3
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h0,0,4'h0,0,1,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h1,0,4'h1,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h3,0,4'h3,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,1, 0,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,1, 0,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h7,0,4'h7,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hF,0,4'hF,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hE,0,4'hE,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hC,0,4'hC,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h8,0,4'h8,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,1));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));
    // Reset after two load beats, then a fresh full load and drain
    vecs.push_back(mk(0,1,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,0,1,32'h93929190,0,0, 1,4'hF,32'h93929190,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'hA3A2A1A0,0,0, 1,4'hF,32'hA3A2A1A0,4'h0,1,0,0));
    vecs.push_back(mk(1,0,0,X,0,0, 1,4'h0,0,4'h0,1,0,0));
    vecs.push_back(mk(1,1,0,X,1,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,1,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));
    vecs.push_back(mk(0,0,1,32'hC3C2C1C0,0,0, 1,4'hF,32'hC3C2C1C0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'hD3D2D1D0,0,0, 1,4'hF,32'hD3D2D1D0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'hE3E2E1E0,0,0, 1,4'hF,32'hE3E2E1E0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,1,32'hF3F2F1F0,0,0, 1,4'hF,32'hF3F2F1F0,4'h0,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,1,0));
    vecs.push_back(mk(0,0,0,X,1,0, 0,4'h0,0,4'h0,0,1,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h1,0,4'h1,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h3,0,4'h3,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h7,0,4'h7,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hF,0,4'hF,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hE,0,4'hE,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'hC,0,4'hC,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h8,0,4'h8,1,0,0));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,1));
    vecs.push_back(mk(0,0,0,X,0,0, 0,4'h0,0,4'h0,0,0,0));

    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      applyStimulus(vecs[r]);
      #1;
      checkOutput(r, vecs[r]);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
